// File: rtl/pipeline_run_ctrl.sv
// Run controller: holds the datapath in reset, releases it for a timed run and stops on a PC halt loop.
// Latency: done/timeout are registered one cycle after the firing sample; start is ignored while busy.
module pipeline_run_ctrl #(
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
    parameter int          RESET_CYCLES = 2,
    parameter int          MAX_CYCLES   = 2000,
    parameter int          THRESH1      = 3,
    parameter int          THRESH2      = 4,
    parameter int          THRESH3      = 6,
    parameter int          THRESH4      = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        stall,
    output logic        core_reset,
    output logic        run_en,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [1:0]  halt_kind,
    output logic [31:0] halt_pc,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_RESET_CORE = 3'd1;
    localparam logic [2:0] S_RUN        = 3'd2;
    localparam logic [2:0] S_DONE       = 3'd3;
    localparam logic [2:0] S_TIMEOUT    = 3'd4;

    logic [2:0]  r_state;
    logic [7:0]  r_rst_cnt;
    logic [31:0] r_hist [1:4];
    logic [31:0] r_prev_instr;
    logic [3:0]  r_m [1:4];
    logic [31:0] r_cycle_count;
    logic [31:0] r_instr_count;
    logic [1:0]  r_halt_kind;
    logic [31:0] r_halt_pc;
    logic        r_core_reset;
    logic        r_run_en;
    logic        r_busy;
    logic        r_done;
    logic        r_timeout;

    logic [4:1]  w_cond;
    logic [4:1]  w_fire;
    logic [3:0]  w_m_nxt [1:4];
    logic        w_any_fire;
    logic [1:0]  w_kind;
    logic [31:0] w_cc_inc;
    logic [31:0] w_ic_nxt;
    logic        w_timeout_hit;
    logic        w_start_acc;
    logic [2:0]  w_next_state;

    function automatic logic [3:0] thresh(input int k);
        case (k)
            1:       return 4'(THRESH1);
            2:       return 4'(THRESH2);
            3:       return 4'(THRESH3);
            default: return 4'(THRESH4);
        endcase
    endfunction

    // The running cycle count doubles as the sample index n, so n >= k gates each comparator.
    always_comb begin
        w_cond = '0;
        w_fire = '0;
        for (int k = 1; k <= 4; k++) begin
            w_m_nxt[k] = '0;
            w_cond[k]  = (pc == r_hist[k]) && (r_cycle_count >= 32'(k));
            if (k == 1) begin
                w_cond[k] = w_cond[k] && (instr == r_prev_instr);
            end
            w_fire[k] = w_cond[k] && ((r_m[k] + 4'd1) == thresh(k));
            if (!w_cond[k]) begin
                w_m_nxt[k] = '0;
            end else if (r_m[k] >= thresh(k)) begin
                w_m_nxt[k] = r_m[k];
            end else begin
                w_m_nxt[k] = r_m[k] + 4'd1;
            end
        end
    end

    always_comb begin
        w_any_fire = |w_fire;
        w_kind     = 2'd3;
        if (w_fire[1]) begin
            w_kind = 2'd0;
        end else if (w_fire[2]) begin
            w_kind = 2'd1;
        end else if (w_fire[3]) begin
            w_kind = 2'd2;
        end
    end

    assign w_cc_inc      = r_cycle_count + 32'd1;
    assign w_ic_nxt      = r_instr_count + (((instr != NOP_INSTR) && !stall) ? 32'd1 : 32'd0);
    assign w_timeout_hit = (w_cc_inc == 32'(MAX_CYCLES));
    assign w_start_acc   = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_TIMEOUT));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (w_start_acc) begin
                    w_next_state = S_RESET_CORE;
                end
            end
            S_RESET_CORE: begin
                if (r_rst_cnt == 8'(RESET_CYCLES - 1)) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_any_fire) begin
                    w_next_state = S_DONE;
                end else if (w_timeout_hit) begin
                    w_next_state = S_TIMEOUT;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output flags are decoded from the next state so every port comes straight from a flop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_rst_cnt     <= '0;
            r_prev_instr  <= '0;
            r_cycle_count <= '0;
            r_instr_count <= '0;
            r_halt_kind   <= '0;
            r_halt_pc     <= '0;
            r_core_reset  <= 1'b1;
            r_run_en      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            for (int k = 1; k <= 4; k++) begin
                r_hist[k] <= '0;
                r_m[k]    <= '0;
            end
        end else begin
            r_state      <= w_next_state;
            r_core_reset <= (w_next_state == S_IDLE) || (w_next_state == S_RESET_CORE);
            r_run_en     <= (w_next_state == S_RESET_CORE) || (w_next_state == S_RUN);
            r_busy       <= (w_next_state == S_RESET_CORE) || (w_next_state == S_RUN);
            r_done       <= (w_next_state == S_DONE);
            r_timeout    <= (w_next_state == S_TIMEOUT);
            if (w_start_acc) begin
                r_rst_cnt     <= '0;
                r_prev_instr  <= '0;
                r_cycle_count <= '0;
                r_instr_count <= '0;
                r_halt_kind   <= '0;
                r_halt_pc     <= '0;
                for (int k = 1; k <= 4; k++) begin
                    r_hist[k] <= '0;
                    r_m[k]    <= '0;
                end
            end else if (r_state == S_RESET_CORE) begin
                r_rst_cnt <= r_rst_cnt + 8'd1;
            end else if (r_state == S_RUN) begin
                r_cycle_count <= w_cc_inc;
                r_instr_count <= w_ic_nxt;
                r_prev_instr  <= instr;
                r_hist[1]     <= pc;
                for (int k = 2; k <= 4; k++) begin
                    r_hist[k] <= r_hist[k-1];
                end
                for (int k = 1; k <= 4; k++) begin
                    r_m[k] <= w_m_nxt[k];
                end
                if (w_any_fire) begin
                    r_halt_kind <= w_kind;
                    r_halt_pc   <= pc;
                end
            end
        end
    end

    assign core_reset  = r_core_reset;
    assign run_en      = r_run_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign halt_kind   = r_halt_kind;
    assign halt_pc     = r_halt_pc;
    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl: three instances differing only in MAX_CYCLES (2000, 10, 8).
module tb_pipeline_run_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] IA  = 32'h0010_0093;
    localparam logic [31:0] IB  = 32'h0020_8113;
    localparam logic [31:0] IJ  = 32'h0000_006F;
    localparam int          NV  = 7;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pc    = '0;
    logic [31:0] instr = '0;

    logic [2:0]        core_reset_w, run_en_w, busy_w, done_w, timeout_w;
    logic [2:0][1:0]   kind_w;
    logic [2:0][31:0]  hpc_w, cc_w, ic_w;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int MC = (g == 0) ? 2000 : ((g == 1) ? 10 : 8);
        pipeline_run_ctrl #(.MAX_CYCLES(MC)) u_dut (
            .clock       (clock),
            .reset       (reset),
            .start       (start),
            .pc          (pc),
            .instr       (instr),
            .stall       (stall),
            .core_reset  (core_reset_w[g]),
            .run_en      (run_en_w[g]),
            .busy        (busy_w[g]),
            .done        (done_w[g]),
            .timeout     (timeout_w[g]),
            .halt_kind   (kind_w[g]),
            .halt_pc     (hpc_w[g]),
            .cycle_count (cc_w[g]),
            .instr_count (ic_w[g])
        );
    end

    typedef struct {
        string             name;
        int                dut;
        int                nsamp;
        logic [11:0][31:0] pcs;
        logic [11:0][31:0] ins;
        logic [11:0]       stl;
        logic              exp_done;
        logic              exp_to;
        logic [1:0]        exp_kind;
        logic [31:0]       exp_pc;
        logic [31:0]       exp_cc;
        logic [31:0]       exp_ic;
    } vec_t;

    vec_t tbl [NV];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_exp(input int i, input string name, input int dut, input int nsamp,
                           input logic d, input logic t, input logic [1:0] k,
                           input logic [31:0] hp, input logic [31:0] cc, input logic [31:0] ic);
        tbl[i].name     = name;
        tbl[i].dut      = dut;
        tbl[i].nsamp    = nsamp;
        tbl[i].exp_done = d;
        tbl[i].exp_to   = t;
        tbl[i].exp_kind = k;
        tbl[i].exp_pc   = hp;
        tbl[i].exp_cc   = cc;
        tbl[i].exp_ic   = ic;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Starts a run from a negedge and returns at the negedge where sample 0 must be driven.
    task automatic do_start(input int d);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        chk("start_core_reset1", 32'(core_reset_w[d]), 32'd1);
        chk("start_busy", 32'(busy_w[d]), 32'd1);
        chk("start_run_en", 32'(run_en_w[d]), 32'd1);
        chk("start_done_clr", 32'(done_w[d]), 32'd0);
        chk("start_timeout_clr", 32'(timeout_w[d]), 32'd0);
        chk("start_cc_clr", cc_w[d], 32'd0);
        chk("start_ic_clr", ic_w[d], 32'd0);
        chk("start_hpc_clr", hpc_w[d], 32'd0);
        chk("start_kind_clr", 32'(kind_w[d]), 32'd0);
        @(posedge clock);
        @(negedge clock);
        chk("start_core_reset2", 32'(core_reset_w[d]), 32'd1);
        @(posedge clock);
        @(negedge clock);
        chk("run_core_reset0", 32'(core_reset_w[d]), 32'd0);
        chk("run_run_en", 32'(run_en_w[d]), 32'd1);
        chk("run_busy", 32'(busy_w[d]), 32'd1);
    endtask

    task automatic run_samples(input int i);
        int d;
        d = tbl[i].dut;
        for (int n = 0; n < tbl[i].nsamp; n++) begin
            pc    = tbl[i].pcs[n];
            instr = tbl[i].ins[n];
            stall = tbl[i].stl[n];
            @(posedge clock);
            @(negedge clock);
            if (n < tbl[i].nsamp - 1) begin
                chk({tbl[i].name, "_early_flags"}, {29'd0, done_w[d], timeout_w[d], run_en_w[d]}, 32'd1);
                chk({tbl[i].name, "_cc_step"}, cc_w[d], 32'(n + 1));
            end
        end
        chk({tbl[i].name, "_done"}, 32'(done_w[d]), 32'(tbl[i].exp_done));
        chk({tbl[i].name, "_timeout"}, 32'(timeout_w[d]), 32'(tbl[i].exp_to));
        chk({tbl[i].name, "_kind"}, 32'(kind_w[d]), 32'(tbl[i].exp_kind));
        chk({tbl[i].name, "_halt_pc"}, hpc_w[d], tbl[i].exp_pc);
        chk({tbl[i].name, "_cycles"}, cc_w[d], tbl[i].exp_cc);
        chk({tbl[i].name, "_instrs"}, ic_w[d], tbl[i].exp_ic);
        chk({tbl[i].name, "_frozen"}, {29'd0, run_en_w[d], busy_w[d], core_reset_w[d]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NV; i++) begin
            for (int n = 0; n < 12; n++) begin
                tbl[i].stl[n] = 1'b0;
                tbl[i].ins[n] = IA;
                case (i)
                    0, 3: begin
                        tbl[i].pcs[n] = (n < 4) ? 32'(4 * n) : 32'h28;
                        tbl[i].ins[n] = (n < 4) ? IA : IJ;
                    end
                    1: begin
                        tbl[i].pcs[n] = (n % 2 == 1) ? 32'h44 : 32'h40;
                        tbl[i].ins[n] = (n % 2 == 1) ? IB : IA;
                    end
                    2: begin
                        tbl[i].pcs[n] = 32'h100 + 32'(4 * n);
                        tbl[i].ins[n] = (n == 2 || n == 3) ? NOP : IA;
                        tbl[i].stl[n] = (n == 6);
                    end
                    4: tbl[i].pcs[n] = 32'h80 + 32'(4 * (n % 3));
                    5: tbl[i].pcs[n] = 32'hC0 + 32'(4 * (n % 4));
                    default: begin
                        tbl[i].pcs[n] = 32'h28;
                        tbl[i].ins[n] = (n % 2 == 1) ? IB : IA;
                    end
                endcase
            end
        end
        set_exp(0, "halt1",   0, 8,  1'b1, 1'b0, 2'd0, 32'h28, 32'd8,  32'd8);
        set_exp(1, "loop2",   0, 6,  1'b1, 1'b0, 2'd1, 32'h44, 32'd6,  32'd6);
        set_exp(2, "count",   1, 10, 1'b0, 1'b1, 2'd0, 32'h0,  32'd10, 32'd7);
        set_exp(3, "simul",   2, 8,  1'b1, 1'b0, 2'd0, 32'h28, 32'd8,  32'd8);
        set_exp(4, "loop3",   0, 9,  1'b1, 1'b0, 2'd2, 32'h88, 32'd9,  32'd9);
        set_exp(5, "loop4",   0, 12, 1'b1, 1'b0, 2'd3, 32'hCC, 32'd12, 32'd12);
        set_exp(6, "pcsame",  0, 6,  1'b1, 1'b0, 2'd1, 32'h28, 32'd6,  32'd6);

        // Power-on reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_outputs", {27'd0, core_reset_w[0], run_en_w[0], busy_w[0], done_w[0], timeout_w[0]}, 32'h10);
        chk("rst_kind", 32'(kind_w[0]), 32'd0);
        chk("rst_halt_pc", hpc_w[0], 32'd0);
        chk("rst_cycles", cc_w[0], 32'd0);
        chk("rst_instrs", ic_w[0], 32'd0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("idle_hold", {30'd0, core_reset_w[0], busy_w[0]}, 32'd2);

        // Reset mid-run, with a start pulse during RUN that must be ignored
        do_start(0);
        for (int n = 0; n < 4; n++) begin
            pc    = tbl[0].pcs[n];
            instr = tbl[0].ins[n];
            stall = 1'b0;
            start = (n == 1);
            if (n == 3) reset = 1'b0;
            @(posedge clock);
            @(negedge clock);
            start = 1'b0;
            if (n == 2) begin
                chk("busy_ignores_start", cc_w[0], 32'd3);
                chk("busy_mid_run", 32'(busy_w[0]), 32'd1);
            end
        end
        reset = 1'b1;
        chk("midrst_flags", {28'd0, core_reset_w[0], run_en_w[0], busy_w[0], done_w[0]}, 32'h8);
        chk("midrst_cycles", cc_w[0], 32'd0);
        chk("midrst_instrs", ic_w[0], 32'd0);
        do_start(0);
        run_samples(0);

        // Frozen in DONE, then restart and reproduce the same run
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
        end
        chk("done_held", 32'(done_w[0]), 32'd1);
        chk("done_cc_held", cc_w[0], 32'd8);
        chk("done_frozen", {30'd0, run_en_w[0], core_reset_w[0]}, 32'd0);
        do_start(0);
        run_samples(0);

        for (int i = 0; i < NV; i++) begin
            do_reset();
            do_start(tbl[i].dut);
            run_samples(i);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_run_ctrl.md
# pipeline_run_ctrl

Run controller for the 5-stage RISC-V pipeline datapath. It holds the core in reset until commanded, releases it for a timed run, and counts cycles and retired instructions. It detects program completion as a halt loop: the fetch PC repeating with period 1, 2, 3 or 4. On completion it freezes the core and latches the results. It turns the simulation-only end-of-program detection into synthesizable hardware usable on FPGA bring-up.

## Interface
- NOP_INSTR, 32'h00000013: encoding excluded from the retired-instruction count.
- RESET_CYCLES, 2: cycles for which core_reset is held after start.
- MAX_CYCLES, 2000: number of RUN cycles before timeout.
- THRESH1 / THRESH2 / THRESH3 / THRESH4, 3 / 4 / 6 / 8: consecutive matches required to detect a loop of period 1 / 2 / 3 / 4.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low.
- start  in  1  begin a run; sampled only in IDLE, DONE or TIMEOUT.
- pc  in  32  datapath fetch PC (pc_current).
- instr  in  32  datapath fetched instruction (instruction_current).
- stall  in  1  datapath hazard stall.
- core_reset  out  1  active-high reset to datapath.
- run_en  out  1  datapath clock enable (freeze when 0).
- busy  out  1  state is RESET_CORE or RUN.
- done  out  1  halt loop detected; level until next start or reset.
- timeout  out  1  MAX_CYCLES reached without detection; level.
- halt_kind  out  2  loop period minus 1 (0 = single-instruction loop).
- halt_pc  out  32  PC of the sample that fired detection.
- cycle_count  out  32  RUN cycles elapsed.
- instr_count  out  32  retired instructions.

## Operation
- States: IDLE, RESET_CORE, RUN, DONE, TIMEOUT. All outputs are registered.
- IDLE: core_reset=1, run_en=0. On start, clear counters, match counters, history and result registers, then go to RESET_CORE.
- RESET_CORE: core_reset=1, run_en=1. After exactly RESET_CYCLES cycles, go to RUN.
- RUN: core_reset=0, run_en=1. Each RUN cycle is one sample n (0-based) of pc, instr and stall.
  - cycle_count increments by 1 on every sample.
  - instr_count increments by 1 when instr != NOP_INSTR and stall=0.
- History: a 4-deep shift of past PCs (hist[1] = previous sample … hist[4]) plus the previous instr.
- Match counter m_k, for k = 1..4, is evaluated only when n >= k.
  - Condition: pc == hist[k]. For k=1 the condition additionally requires instr == previous instr.
  - If the condition holds, m_k increments (saturating at its threshold); otherwise m_k is cleared to 0.
- Detection fires on the sample where an incremented m_k reaches THRESHk. Priority when several fire in the same sample: k=1 > 2 > 3 > 4.
  - On firing, go to DONE. Latch halt_kind=k-1 and halt_pc=pc. The firing sample is included in both counts.
- Timeout fires when a sample makes cycle_count equal MAX_CYCLES and no detection fires on that sample; go to TIMEOUT. If both occur on the same sample, detection wins.
- DONE / TIMEOUT: core_reset=0, run_en=0 (core frozen for inspection). Counters and results are held.
  - start begins a new run (same clearing as from IDLE).
- Counters wrap modulo 2^32; this is unreachable with MAX_CYCLES < 2^32.

## Timing
- Reset (reset=0 at an edge) returns to IDLE from any state, including mid-RUN.
  - core_reset=1; run_en, busy, done, timeout = 0.
  - halt_kind=0, halt_pc=0, cycle_count=0, instr_count=0; history and match counters are cleared.
- start sampled high in IDLE at edge t: core_reset is high for edges t+1 … t+RESET_CYCLES; the first RUN sample is at edge t+RESET_CYCLES+1.
- done or timeout is visible the cycle after the firing sample edge; run_en=0 in that same cycle.
- start is ignored while busy=1.

## Test plan
- Single-instruction halt: PCs 0x00, 0x04, 0x08, 0x0C, then 0x28 held with instr 0x0000006F, no stall.
  - Required: done=1, halt_kind=0, halt_pc=0x28, cycle_count=8, instr_count=8, run_en=0.
- Two-instruction loop: alternate PC 0x40 / 0x44 from sample 0 (differing instr).
  - Required: fires at sample 5 with halt_kind=1, halt_pc=0x44, cycle_count=6; no earlier period-1 fire.
- Counting: 10 samples of increasing PC, where samples 2 and 3 carry instr 0x00000013 and sample 6 has stall=1; MAX_CYCLES=10.
  - Required: timeout=1, done=0, cycle_count=10, instr_count=7.
- Simultaneous events: MAX_CYCLES=8 with the single-instruction-halt stimulus above.
  - Required: done=1, timeout=0.
- Reset mid-run: assert reset at sample 3.
  - Required next cycle: IDLE, core_reset=1, all counters 0. A subsequent start gives core_reset high for exactly 2 cycles and then a fresh run.
- Restart from DONE: pulse start.
  - Required: done drops, counters cleared, busy=1, then a second identical run reproduces the same results.
